dual_port_ram_arbiter: RTL

- Shares one 128x8 dual-port SRAM (separate write and read ports, registered read, 1-cycle read latency) between two requesters, A and B.
- Each RAM port is arbitrated independently with round-robin priority, so one write and one read can both be granted in the same cycle.
- Read data returns to the requester that won the read.
- Sits between two client blocks (e.g. multiplier operand/result stages) and the RAM macro wrapper.

---
 rtl/dual_port_ram_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/dual_port_ram_arbiter.sv
// Round-robin arbiter sharing one 1R1W RAM between requesters A and B; grants are same-cycle, read data returns one cycle after grant.
// Optional write-first forwarding on same-address write/read collisions: define DUAL_PORT_RAM_ARBITER_BYPASS_EN.
module dual_port_ram_arbiter #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_ren,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  logic r_wptr;
  logic r_rptr;
  logic r_rpend;
  logic r_rsel;

  logic w_wreq_a, w_wreq_b, w_rreq_a, w_rreq_b;
  logic w_wsel, w_rsel;
  logic w_wen, w_ren;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Requests are masked during reset so nothing is granted or launched.
  assign w_wreq_a = rst_n & a_req & a_we;
  assign w_wreq_b = rst_n & b_req & b_we;
  assign w_rreq_a = rst_n & a_req & ~a_we;
  assign w_rreq_b = rst_n & b_req & ~b_we;

  // Winner select: 0 = A, 1 = B; the pointer only matters when both compete.
  assign w_wsel = w_wreq_b & (~w_wreq_a | r_wptr);
  assign w_rsel = w_rreq_b & (~w_rreq_a | r_rptr);

  assign w_wen = w_wreq_a | w_wreq_b;
  assign w_ren = w_rreq_a | w_rreq_b;

  assign a_gnt = (w_wen & ~w_wsel) | (w_ren & ~w_rsel);
  assign b_gnt = (w_wen &  w_wsel) | (w_ren &  w_rsel);

  assign ram_wen   = w_wen;
  assign ram_ren   = w_ren;
  assign ram_waddr = !w_wen ? '0 : (w_wsel ? b_addr  : a_addr);
  assign ram_din   = !w_wen ? '0 : (w_wsel ? b_wdata : a_wdata);
  assign ram_raddr = !w_ren ? '0 : (w_rsel ? b_addr  : a_addr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_rpend <= 1'b0;
      r_rsel  <= 1'b0;
    end else begin
      // A contended grant hands priority to the loser.
      if (w_wreq_a & w_wreq_b) r_wptr <= ~r_wptr;
      if (w_rreq_a & w_rreq_b) r_rptr <= ~r_rptr;
      r_rpend <= w_ren;
      r_rsel  <= w_rsel;
    end
  end

`ifdef DUAL_PORT_RAM_ARBITER_BYPASS_EN
  logic                  r_byp_vld;
  logic [DATA_WIDTH-1:0] r_byp_dat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_byp_vld <= 1'b0;
      r_byp_dat <= '0;
    end else begin
      r_byp_vld <= w_wen & w_ren & (ram_waddr == ram_raddr);
      r_byp_dat <= ram_din;
    end
  end

  assign w_rdata = r_byp_vld ? r_byp_dat : ram_dout;
`else
  assign w_rdata = ram_dout;
`endif

  assign a_rvalid = r_rpend & ~r_rsel;
  assign b_rvalid = r_rpend &  r_rsel;
  assign a_rdata  = a_rvalid ? w_rdata : '0;
  assign b_rdata  = b_rvalid ? w_rdata : '0;

endmodule
